// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared definitions for the pipeline-enable controller: state encoding and
// the legal range of the stage-count parameter.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned STAGES_MIN = 2;
  localparam int unsigned STAGES_MAX = 8;

  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// Control/status bundle between the pipeline-enable controller (slave side)
// and whatever sequences it (master side).
interface pipe_ctrl_fsm_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 3
) ();

  localparam int unsigned OCC_W = occ_width(STAGES);

  logic              start;
  logic              stall;
  logic              flush;
  logic              drain_req;
  logic [STAGES-1:0] stage_en;
  logic [OCC_W-1:0]  occupancy;
  logic              full;
  logic              busy;
  logic              drain_done;

  modport master (
    output start, stall, flush, drain_req,
    input  stage_en, occupancy, full, busy, drain_done
  );

  modport slave (
    input  start, stall, flush, drain_req,
    output stage_en, occupancy, full, busy, drain_done
  );

endinterface

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline-enable controller: one enable per stage with fill, stall, flush
// and drain. All outputs are registers; nothing combinational from inputs.
module pipe_ctrl_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_ctrl_fsm_if.slave bus
);

  localparam int unsigned OCC_W = occ_width(STAGES);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pipe_ctrl_fsm: STAGES=%0d outside legal range %0d..%0d",
           STAGES, STAGES_MIN, STAGES_MAX);
  end

  state_t            state;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_fill;
  logic [STAGES-1:0] v_drain;
  logic [OCC_W-1:0]  occ;
  logic              full_r;
  logic              busy_r;
  logic              done_r;

  always_comb begin
    v_fill  = {v[STAGES-2:0], 1'b1};
    v_drain = {v[STAGES-2:0], 1'b0};
  end

  // Occupancy tracks popcount(v) incrementally; during a drain a bit only
  // leaves the pipe when it shifts out of the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      v      <= '0;
      occ    <= '0;
      full_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.flush) begin
        v      <= '0;
        occ    <= '0;
        full_r <= 1'b0;
        if (state == FILL || state == FULL) begin
          state  <= FILL;
          busy_r <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      end else if (!bus.stall) begin
        unique case (state)
          IDLE: begin
            if (!bus.drain_req && bus.start) begin
              state  <= FILL;
              v      <= v_fill;
              occ    <= OCC_W'(1);
              busy_r <= 1'b1;
              full_r <= 1'b0;
            end
          end
          FILL: begin
            if (bus.drain_req) begin
              full_r <= 1'b0;
              if (v == '0 || v_drain == '0) begin
                state  <= IDLE;
                v      <= '0;
                occ    <= '0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                state <= DRAIN;
                v     <= v_drain;
                if (v[STAGES-1]) occ <= occ - OCC_W'(1);
              end
            end else begin
              v   <= v_fill;
              occ <= occ + OCC_W'(1);
              if (&v_fill) begin
                state  <= FULL;
                full_r <= 1'b1;
              end
            end
          end
          FULL: begin
            if (bus.drain_req) begin
              state  <= DRAIN;
              v      <= v_drain;
              full_r <= 1'b0;
              if (v[STAGES-1]) occ <= occ - OCC_W'(1);
            end
          end
          DRAIN: begin
            v <= v_drain;
            if (v[STAGES-1]) occ <= occ - OCC_W'(1);
            if (v_drain == '0) begin
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            v      <= '0;
            occ    <= '0;
            full_r <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.stage_en   = v;
  assign bus.occupancy  = occ;
  assign bus.full       = full_r;
  assign bus.busy       = busy_r;
  assign bus.drain_done = done_r;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Self-checking bench for pipe_ctrl_fsm with STAGES=3 and STAGES=8 instances;
// expected outputs are queued with each stimulus row and popped after the edge.
module tb_pipe_ctrl_fsm;

  typedef struct packed {
    logic [7:0] en;
    logic [3:0] occ;
    logic       full;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic rst_n;
    logic start;
    logic stall;
    logic flush;
    logic drain;
    obs_t e;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n3, rst_n8;
  always #5 clk = ~clk;

  pipe_ctrl_fsm_if #(.STAGES(3)) i3 ();
  pipe_ctrl_fsm_if #(.STAGES(8)) i8 ();

  pipe_ctrl_fsm #(.STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n3), .bus(i3.slave));
  pipe_ctrl_fsm #(.STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n8), .bus(i8.slave));

  obs_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic stim_t r(logic rn, logic st, logic sl, logic fl, logic dr,
                              logic [7:0] en, logic [3:0] occ,
                              logic full, logic busy, logic done);
    stim_t s;
    s.rst_n  = rn;  s.start  = st;  s.stall = sl;  s.flush = fl;  s.drain = dr;
    s.e.en   = en;  s.e.occ  = occ; s.e.full = full;
    s.e.busy = busy; s.e.done = done;
    return s;
  endfunction

  function automatic obs_t snap(input bit big);
    obs_t o;
    if (big) begin
      o.en = i8.stage_en;        o.occ = i8.occupancy;
      o.full = i8.full;          o.busy = i8.busy;  o.done = i8.drain_done;
    end else begin
      o.en = {5'b0, i3.stage_en}; o.occ = {2'b0, i3.occupancy};
      o.full = i3.full;           o.busy = i3.busy; o.done = i3.drain_done;
    end
    return o;
  endfunction

  task automatic apply(input bit big, input stim_t s);
    if (big) begin
      rst_n8 = s.rst_n; i8.start = s.start; i8.stall = s.stall;
      i8.flush = s.flush; i8.drain_req = s.drain;
    end else begin
      rst_n3 = s.rst_n; i3.start = s.start; i3.stall = s.stall;
      i3.flush = s.flush; i3.drain_req = s.drain;
    end
    exp_q.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t rows[$];
    obs_t o, x;
    rows.push_back(r(0,1,0,0,0, 8'h00,0,0,0,0));
    rows.push_back(r(0,0,0,0,1, 8'h00,0,0,0,0));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    rows.push_back(r(1,0,0,0,1, 8'h00,0,0,0,0)); // drain_req alone in IDLE
    rows.push_back(r(1,0,0,1,0, 8'h00,0,0,0,0)); // flush in IDLE
    foreach (rows[i]) begin
      apply(1'b0, rows[i]);
      o = snap(1'b0); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL reset[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  task automatic test_fill_drain();
    stim_t rows[$];
    obs_t o, x;
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h06,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h04,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,1));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    // drain from FILL with v=001 still takes three edges
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h02,1,0,1,0));
    rows.push_back(r(1,1,0,0,0, 8'h04,1,0,1,0));
    rows.push_back(r(1,1,0,0,0, 8'h00,0,0,0,1));
    foreach (rows[i]) begin
      apply(1'b0, rows[i]);
      o = snap(1'b0); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL fill_drain[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  task automatic test_stall();
    stim_t rows[$];
    obs_t o, x;
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,1,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,1,0,1, 8'h03,2,0,1,0)); // stall beats drain_req
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h06,2,0,1,0));
    rows.push_back(r(1,0,1,0,0, 8'h06,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h04,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,1));
    rows.push_back(r(1,0,1,0,0, 8'h00,0,0,0,0));
    foreach (rows[i]) begin
      apply(1'b0, rows[i]);
      o = snap(1'b0); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL stall[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  task automatic test_flush();
    stim_t rows[$];
    obs_t o, x;
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,1,1,1, 8'h00,0,0,1,0)); // flush wins over stall
    rows.push_back(r(1,0,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,0,1,0, 8'h00,0,0,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h00,0,0,0,1)); // drain on empty FILL
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h02,1,0,1,0));
    rows.push_back(r(1,0,0,1,0, 8'h00,0,0,0,0)); // flush in DRAIN: silent idle
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    foreach (rows[i]) begin
      apply(1'b0, rows[i]);
      o = snap(1'b0); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL flush[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    stim_t rows[$];
    obs_t o, x;
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h03,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h07,3,1,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h06,2,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h04,1,0,1,0));
    rows.push_back(r(0,1,1,1,1, 8'h00,0,0,0,0));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    rows.push_back(r(1,0,0,0,1, 8'h02,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h04,1,0,1,0));
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,1));
    foreach (rows[i]) begin
      apply(1'b0, rows[i]);
      o = snap(1'b0); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL reset_mid_drain[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  task automatic test_stages8();
    stim_t rows[$];
    obs_t o, x;
    logic [7:0] en;
    rows.push_back(r(0,0,0,0,0, 8'h00,0,0,0,0));
    for (int k = 1; k <= 8; k++) begin
      en = 8'((16'd1 << k) - 16'd1);
      rows.push_back(r(1, (k == 1), 0, 0, 0, en, 4'(k), (k == 8), 1, 0));
    end
    for (int j = 1; j <= 8; j++) begin
      en = 8'hFF << j;
      rows.push_back(r(1, (j % 2 == 0) && (j > 1), 0, 0, (j == 1),
                       en, 4'(8 - j), 0, (j < 8), (j == 8)));
    end
    rows.push_back(r(1,0,0,0,0, 8'h00,0,0,0,0));
    rows.push_back(r(1,1,0,0,0, 8'h01,1,0,1,0));
    foreach (rows[i]) begin
      apply(1'b1, rows[i]);
      o = snap(1'b1); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin
        n_bad++;
        $display("FAIL stages8[%0d]: got en=%b occ=%0d full=%b busy=%b done=%b want en=%b occ=%0d full=%b busy=%b done=%b",
                 i, o.en, o.occ, o.full, o.busy, o.done, x.en, x.occ, x.full, x.busy, x.done);
      end
    end
  endtask

  initial begin
    rst_n3 = 1'b0; rst_n8 = 1'b0;
    i3.start = 1'b0; i3.stall = 1'b0; i3.flush = 1'b0; i3.drain_req = 1'b0;
    i8.start = 1'b0; i8.stall = 1'b0; i8.flush = 1'b0; i8.drain_req = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_stall();
    test_flush();
    test_reset_mid_drain();
    test_stages8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_fsm.md
# pipe_ctrl_fsm

Parametrised pipeline-enable controller for the in-order datapath. It generates one enable per pipeline stage and adds four behaviours to the fixed 3-stage fill sequencer: a configurable stage count, stall (freeze), flush (clear and refill), and an orderly drain back to idle. It sits beside the datapath and drives the per-stage register enables.

## Interface
- STAGES, 3, number of pipeline stages; legal range 2..8.
- OCC_W, $clog2(STAGES+1), width of the occupancy count (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  begin filling; honoured only in IDLE.
- stall  input  1  freeze state, stage_en and occupancy for this cycle.
- flush  input  1  clear all stage valids.
- drain_req  input  1  stop feeding stage 0 and let the pipe empty.
- stage_en  output  STAGES  per-stage enable; bit 0 is the first stage.
- occupancy  output  OCC_W  number of set bits in stage_en.
- full  output  1  high when stage_en is all ones.
- busy  output  1  high when state is not IDLE.
- drain_done  output  1  one-cycle pulse on entering IDLE from DRAIN or FILL.

## Operation
- States: IDLE, FILL, FULL, DRAIN.
- Internal valid vector v[STAGES-1:0]; stage_en = v. Every output is a register or a decode of registers; there is no input-to-output combinational path.
- Advance operation: v <= {v[STAGES-2:0], feed}.
  - feed = 1 in FILL and FULL.
  - feed = 0 in DRAIN.
- Occupancy is maintained incrementally:
  - +1 per advance in FILL.
  - −1 per advance in DRAIN, applied only while v[STAGES-1] = 1.
  - Unchanged in FULL.
- Priority per edge: !rst_n > flush > stall > drain_req > start.
- Reset: state = IDLE, v = 0, occupancy = 0, full = 0, busy = 0, drain_done = 0.
- flush:
  - Sets v = 0 and occupancy = 0.
  - From FILL or FULL, next state is FILL and refill starts on the next non-stall edge.
  - From DRAIN or IDLE, next state is IDLE with no drain_done pulse.
- stall: state, v and occupancy hold; drain_done is forced to 0.
- IDLE:
  - start → FILL, and v[0] is set on the same edge.
  - drain_req alone is ignored.
- FILL:
  - drain_req → DRAIN. If v = 0 (just after a flush), go directly to IDLE and pulse drain_done instead.
  - Otherwise advance; go to FULL on the edge where v becomes all ones.
- FULL:
  - Hold with v all ones.
  - drain_req → DRAIN and advance with feed = 0 on the same edge.
- DRAIN:
  - Advance with feed = 0.
  - Go to IDLE on the edge where v becomes 0, and raise drain_done for exactly one cycle.
  - start is ignored; the pipe must return to IDLE before a new start.
- v is always a contiguous run of ones: LSB-aligned during FILL, MSB-aligned during DRAIN.

## Timing
- start sampled at edge 0 → stage_en[0] = 1 after edge 0; full = 1 after edge STAGES−1, i.e. STAGES cycles of fill.
- drain_req sampled in FULL → v reaches 0, state reaches IDLE and drain_done = 1, all after exactly STAGES edges.
- A drain from FILL with v ≠ 0 also takes exactly STAGES edges.
- A stall cycle extends any sequence by exactly one cycle.
- A flush in FULL followed by no stall → full again after STAGES+1 edges (one flush edge plus STAGES fill edges).
- Reset asserted mid-operation takes effect on that edge, regardless of any other input.

## Structure
- Shared package pipe_ctrl_pkg holds the state encoding (2-bit, IDLE = 0, FILL = 1, FULL = 2, DRAIN = 3) and the STAGES legal-range constants.
- Single module, no sub-modules. The valid vector and occupancy counter are in-line registers.
- An elaboration-time check rejects STAGES outside 2..8.

## Test plan
- Reset, then start at cycle 0, STAGES = 3 → stage_en 001, 011, 111; full after the 3rd edge; occupancy 1, 2, 3; busy from the 1st edge.
- From FULL, drain_req for one cycle → stage_en 110, 100, 000; drain_done high only in the cycle where v = 000; state IDLE.
- During FILL at v = 011, stall held for 2 cycles, then released → v stays 011 for 2 cycles, then reaches 111 one edge later.
- In FULL, flush and stall asserted together → v = 000 (flush wins); refill reaches 111 three edges later; no drain_done.
- STAGES = 8: full start/drain round trip → 8-edge fill and 8-edge drain; occupancy reaches 8 (OCC_W = 4); start pulses during DRAIN are ignored.
- rst_n low mid-DRAIN at v = 100, with start high → all outputs zero on that edge; start is only honoured after rst_n returns high.
